// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified instruction/data memory path.
// Arbiter states, grant encoding and default bus widths.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } grant_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts stalled memory cycles and raises a sticky hit flag.
// hit_o rises so that it is visible during the TIMEOUT-th stalled cycle.
module arb_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic hit_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          hit_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            hit_q <= 1'b0;
        end else begin
            if (clr_i) begin
                cnt_q <= '0;
            end else if (en_i && cnt_q != CW'(TIMEOUT)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Set one cycle early so the flag is already up in the limit cycle.
            if (en_i && cnt_q >= CW'(TIMEOUT - 2)) begin
                hit_q <= 1'b1;
            end
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared between instruction fetch and data access.
// One transaction at a time; DM has priority unless IF has starved.
module unified_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_o
);

    arb_state_t        state_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic              err_q;

    logic   dm_req;
    logic   starved;
    logic   busy;
    logic   to_hit;
    grant_t grant_d;

    always_comb begin
        dm_req   = dm_read_i | dm_write_i;
        starved  = (starve_q == 4'(STARVE_LIMIT));
        busy     = (state_q == BUSY_IF) || (state_q == BUSY_DM);
        grant_d  = GNT_IF;
        starve_d = starve_q;
        if (dm_req && !(if_req_i && starved)) begin
            grant_d = GNT_DM;
            if (if_req_i && !starved) begin
                starve_d = starve_q + 1'b1;
            end
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            if (dm_read_i && dm_write_i) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (dm_req || if_req_i) begin
                        mem_req_q <= 1'b1;
                        starve_q  <= starve_d;
                        if (grant_d == GNT_DM) begin
                            state_q     <= BUSY_DM;
                            mem_we_q    <= dm_write_i;
                            mem_addr_q  <= dm_addr_i;
                            mem_wdata_q <= dm_wdata_i;
                        end else begin
                            state_q     <= BUSY_IF;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr_i;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (state_q == BUSY_IF) begin
                            if_rdata_q <= mem_rdata_i;
                            if_ack_q   <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata_i;
                            end
                            dm_ack_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    arb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (busy & ~mem_ready_i),
        .clr_i(~busy),
        .hit_o(to_hit)
    );

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q | to_hit;
    assign if_stall_o  = if_req_i & ~if_ack_q;
    assign dm_stall_o  = (dm_read_i | dm_write_i) & ~dm_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed scenarios plus a
// randomized phase checked against a queue/array memory reference.
module tb_unified_mem_arbiter;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        if_stall_o;
    logic        dm_read_i = 1'b0;
    logic        dm_write_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        dm_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        err_o;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .if_stall_o(if_stall_o),
        .dm_read_i(dm_read_i), .dm_write_i(dm_write_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } dm_t;

    int checks = 0;
    int passes = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] if_q [$];
    dm_t         dm_q [$];
    dm_t         wr_q [$];
    logic [31:0] addr_log [$];
    logic [31:0] exp_dm_rdata = '0;

    int   fix_lat = 1;
    bit   noise = 1'b0;
    logic e63 = 1'bx;
    logic e64 = 1'bx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] seed(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed(a);
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : seed(a);
    endfunction

    // Memory device: variable latency, optional ready noise outside transfers.
    initial begin : responder
        int          busy_n;
        int          lat_t;
        logic [31:0] t_addr;
        logic [31:0] t_wd;
        logic        t_we;
        dm_t         w;
        busy_n = 0;
        lat_t = 1;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i) begin
                busy_n = 0;
                mem_ready_i = 1'b0;
            end else if (mem_req_o) begin
                busy_n++;
                if (busy_n == 1) begin
                    lat_t = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 4));
                    t_addr = mem_addr_o;
                    t_wd = mem_wdata_o;
                    t_we = mem_we_o;
                    addr_log.push_back(mem_addr_o);
                    if (mem_we_o) begin
                        if (wr_q.size() == 0) begin
                            chk("mem_unexpected_write", 32'd1, 32'd0);
                        end else begin
                            w = wr_q.pop_front();
                            chk("mem_wr_addr", mem_addr_o, w.addr);
                            chk("mem_wr_data", mem_wdata_o, w.data);
                        end
                    end
                end else begin
                    chk("mem_addr_stable", mem_addr_o, t_addr);
                    chk("mem_we_stable", 32'(mem_we_o), 32'(t_we));
                    if (t_we) chk("mem_wdata_stable", mem_wdata_o, t_wd);
                end
                if (busy_n == TO - 1) e63 = err_o;
                if (busy_n == TO) e64 = err_o;
                mem_ready_i = (busy_n == lat_t);
                mem_rdata_i = mem_ready_i ? dev_rd(mem_addr_o) : $urandom;
                if (mem_ready_i && t_we) dev_mem[t_addr] = t_wd;
            end else begin
                busy_n = 0;
                mem_ready_i = noise ? 1'($urandom % 2) : 1'b0;
                mem_rdata_i = $urandom;
            end
        end
    end

    // Scoreboard monitor: pops expected responses on each ack pulse.
    initial begin : monitor
        logic [31:0] e;
        dm_t         d;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (if_ack_o) begin
                    if (if_q.size() == 0) begin
                        chk("if_spurious_ack", 32'd1, 32'd0);
                    end else begin
                        e = if_q.pop_front();
                        chk("if_rdata", if_rdata_o, e);
                    end
                end
                if (dm_ack_o) begin
                    if (dm_q.size() == 0) begin
                        chk("dm_spurious_ack", 32'd1, 32'd0);
                    end else begin
                        d = dm_q.pop_front();
                        if (d.we) begin
                            chk("dm_rdata_hold", dm_rdata_o, exp_dm_rdata);
                        end else begin
                            chk("dm_rdata", dm_rdata_o, d.data);
                            exp_dm_rdata = d.data;
                        end
                    end
                end
            end
        end
    end

    task automatic if_fetch(input logic [31:0] a, output int n);
        if_req_i = 1'b1;
        if_addr_i = a;
        if_q.push_back(ref_rd(a));
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (if_ack_o) break;
        end
        if (!if_ack_o) chk("if_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if_req_i = 1'b0;
    endtask

    task automatic dm_access(input bit we, input logic [31:0] a,
                             input logic [31:0] wd, output int n);
        dm_t t;
        dm_read_i = !we;
        dm_write_i = we;
        dm_addr_i = a;
        dm_wdata_i = wd;
        t.we = we;
        t.addr = a;
        t.data = we ? wd : ref_rd(a);
        dm_q.push_back(t);
        if (we) begin
            ref_mem[a] = wd;
            wr_q.push_back(t);
        end
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (dm_ack_o) break;
        end
        if (!dm_ack_o) chk("dm_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        dm_read_i = 1'b0;
        dm_write_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        if_q.delete();
        dm_q.delete();
        wr_q.delete();
        exp_dm_rdata = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic starve_round();
        int n;
        logic [31:0] exp_log [6];
        exp_log = '{32'h2000, 32'h2004, 32'h2008, 32'h200C,
                    32'h1000, 32'h2010};
        addr_log.delete();
        fork
            if_fetch(32'h1000, n);
            for (int i = 0; i < 5; i++) begin
                int m;
                dm_access(1'b0, 32'h2000 + 32'(4 * i), '0, m);
            end
        join
        chk("starve_log_len", 32'(addr_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
            chk("starve_order", addr_log[i], exp_log[i]);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int hi;
        int wn;
        int k;
        int acks;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_if_ack", 32'(if_ack_o), 32'd0);
        chk("rst_dm_ack", 32'(dm_ack_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        chk("rst_dm_rdata", dm_rdata_o, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // 1: IF-only fetch, ready on first BUSY cycle
        fix_lat = 1;
        ref_mem[32'h10] = 32'h0011_2233;
        dev_mem[32'h10] = 32'h0011_2233;
        if_fetch(32'h10, n);
        chk("t1_if_latency", 32'(n), 32'd3);
        chk("t1_if_rdata", if_rdata_o, 32'h0011_2233);

        // 2: simultaneous IF and DM reads, DM first
        addr_log.delete();
        hi = 0;
        wn = 0;
        fork
            if_fetch(32'h1040, n);
            dm_access(1'b0, 32'h2040, '0, k);
            begin
                repeat (8) begin
                    @(negedge clk);
                    if (if_req_i && !if_ack_o) begin
                        wn++;
                        if (if_stall_o) hi++;
                    end
                end
            end
        join
        chk("t2_first_dm", addr_log[0], 32'h2040);
        chk("t2_then_if", addr_log[1], 32'h1040);
        chk("t2_if_wait", 32'(wn), 32'd5);
        chk("t2_if_stall", 32'(hi), 32'(wn));

        // 3: DM back-to-back starves IF, then counter restarts
        starve_round();
        starve_round();

        // 4: DM write leaves dm_rdata_o alone
        fix_lat = 3;
        dm_access(1'b0, 32'h2100, '0, n);
        dm_access(1'b1, 32'h100, 32'hDEAD_BEEF, n);
        chk("t4_rdata_kept", dm_rdata_o, ref_rd(32'h2100));
        chk("t4_dev_written", dev_rd(32'h100), 32'hDEAD_BEEF);
        fix_lat = 1;
        dm_access(1'b0, 32'h100, '0, n);

        // 6: reset in the middle of a read+write transaction
        chk("t6_err_before", 32'(err_o), 32'd0);
        fix_lat = 100;
        wr_q.push_back('{1'b1, 32'h300, 32'h1234_5678});
        dm_addr_i = 32'h300;
        dm_wdata_i = 32'h1234_5678;
        dm_read_i = 1'b1;
        dm_write_i = 1'b1;
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(posedge clk);
            #1;
            if (mem_req_o) k++;
        end
        chk("t6_busy", 32'(k), 32'd3);
        chk("t6_err_rw", 32'(err_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_req", 32'(mem_req_o), 32'd0);
        chk("t6_rst_we", 32'(mem_we_o), 32'd0);
        chk("t6_rst_err", 32'(err_o), 32'd0);
        chk("t6_rst_wdata", mem_wdata_o, 32'd0);
        chk("t6_rst_rdata", dm_rdata_o, 32'd0);
        dm_read_i = 1'b0;
        dm_write_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        exp_dm_rdata = '0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (dm_ack_o) acks++;
        end
        chk("t6_no_ack", 32'(acks), 32'd0);
        chk("t6_idle_req", 32'(mem_req_o), 32'd0);
        @(posedge clk);
        #1;

        // 5: memory withholds ready past the timeout
        fix_lat = 70;
        e63 = 1'bx;
        e64 = 1'bx;
        dm_access(1'b0, 32'h2200, '0, n);
        chk("t5_err_at_63", 32'(e63), 32'd0);
        chk("t5_err_at_64", 32'(e64), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_err_sticky", 32'(err_o), 32'd1);
        do_reset();
        ref_mem.delete();
        dev_mem.delete();

        // Randomized concurrent traffic with ready noise
        fix_lat = 0;
        noise = 1'b1;
        fork
            for (int i = 0; i < 40; i++) begin
                int m;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                if_fetch(32'h1000 + 32'(4 * $urandom_range(0, 63)), m);
            end
            for (int i = 0; i < 40; i++) begin
                int m;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                dm_access(1'($urandom % 2),
                          32'h2000 + 32'(4 * $urandom_range(0, 15)),
                          $urandom, m);
            end
        join
        noise = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_if_q_empty", 32'(if_q.size()), 32'd0);
        chk("rand_dm_q_empty", 32'(dm_q.size()), 32'd0);
        chk("rand_wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("rand_no_err", 32'(err_o), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
